// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage : execute stage of the 5-stage MIPS pipeline.
//
// Computes the single-cycle ALU result combinationally and owns the HI/LO
// registers. An iterative multiply/divide unit (one bit per cycle) stalls the
// front of the pipeline while it runs and writes HI/LO when it finishes.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset (0 = reset)
//   EXE_flush    squash the instruction in EXE, abort any in-flight mult/div
//   EXE_alu_ctrl 6-bit operation code
//   EXE_s_b      operand-B select: 1 = EXE_ex_imm, 0 = EXE_b
//   EXE_pc       PC of the instruction in EXE
//   EXE_a        operand A (rs)
//   EXE_b        operand B (rt)
//   EXE_ex_imm   extended immediate
//   EXE_alu_out  result to the EXE/MEM register
//   EXE_stall    hold PC, IF/ID and ID/EXE
//   EXE_md_busy  high while the mult/div unit is iterating
// -----------------------------------------------------------------------------
module exe_stage #(
    parameter int XLEN     = 32,
    parameter int MD_ITERS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            EXE_flush,
    input  logic [5:0]      EXE_alu_ctrl,
    input  logic            EXE_s_b,
    input  logic [31:0]     EXE_pc,
    input  logic [XLEN-1:0] EXE_a,
    input  logic [XLEN-1:0] EXE_b,
    input  logic [XLEN-1:0] EXE_ex_imm,
    output logic [XLEN-1:0] EXE_alu_out,
    output logic            EXE_stall,
    output logic            EXE_md_busy
);

    localparam int CNT_W = $clog2(MD_ITERS);
    localparam int SH_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITERS - 1);

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_AND   = 6'h03;
    localparam logic [5:0] OP_OR    = 6'h04;
    localparam logic [5:0] OP_XOR   = 6'h05;
    localparam logic [5:0] OP_NOR   = 6'h06;
    localparam logic [5:0] OP_SLT   = 6'h07;
    localparam logic [5:0] OP_SLTU  = 6'h08;
    localparam logic [5:0] OP_SLL   = 6'h09;
    localparam logic [5:0] OP_SRL   = 6'h0A;
    localparam logic [5:0] OP_SRA   = 6'h0B;
    localparam logic [5:0] OP_LUI   = 6'h0C;
    localparam logic [5:0] OP_MFHI  = 6'h14;
    localparam logic [5:0] OP_MFLO  = 6'h15;
    localparam logic [5:0] OP_MTHI  = 6'h16;
    localparam logic [5:0] OP_MTLO  = 6'h17;
    localparam logic [5:0] OP_LINK  = 6'h18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Two's-complement negate when n is set.
    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_wide(input logic n, input logic [2*XLEN-1:0] v);
        return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    // Shared iteration register: {partial, multiplier} or {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   bmag_q, bmag_d;
    logic [XLEN-1:0]   araw_q, araw_d;
    logic              is_div_q, is_div_d;
    logic              neg_prod_q, neg_prod_d;   // negate product / quotient
    logic              neg_rem_q, neg_rem_d;     // negate remainder
    logic              dz_q, dz_d;               // divide by zero

    logic [XLEN-1:0]   op_b_s;
    logic              is_md_s;
    logic              md_signed_s;
    logic              a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic [XLEN:0]     mult_sum_s;
    logic [XLEN:0]     div_trial_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   div_sub_s;
    logic [2*XLEN-1:0] step_acc_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   res_hi_s, res_lo_s;
    logic [XLEN-1:0]   alu_s;
    logic              stall_s;
    logic [SH_W-1:0]   sh_s;

    // Operand selection and mult/div operand conditioning.
    always_comb begin
        op_b_s      = EXE_s_b ? EXE_ex_imm : EXE_b;
        is_md_s     = (EXE_alu_ctrl[5:2] == 4'b0100);
        md_signed_s = ~EXE_alu_ctrl[0];
        a_neg_s     = md_signed_s & EXE_a[XLEN-1];
        b_neg_s     = md_signed_s & op_b_s[XLEN-1];
        a_mag_s     = neg_if(a_neg_s, EXE_a);
        b_mag_s     = neg_if(b_neg_s, op_b_s);
        sh_s        = EXE_a[SH_W-1:0];
    end

    // One iteration of shift-add multiply or restoring divide on magnitudes.
    always_comb begin
        mult_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                    + (acc_q[0] ? {1'b0, bmag_q} : {(XLEN+1){1'b0}});
        div_trial_s = acc_q[2*XLEN-1:XLEN-1];
        div_ge_s    = (div_trial_s >= {1'b0, bmag_q});
        // The true difference is below bmag_q, so the low XLEN bits are exact.
        div_sub_s   = div_trial_s[XLEN-1:0] - bmag_q;
        if (is_div_q) begin
            if (div_ge_s) begin
                step_acc_s = {div_sub_s, acc_q[XLEN-2:0], 1'b1};
            end else begin
                step_acc_s = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            step_acc_s = {mult_sum_s, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and divide-by-zero override of the final iteration result.
    always_comb begin
        prod_s = neg_if_wide(neg_prod_q, step_acc_s);
        if (is_div_q) begin
            if (dz_q) begin
                res_lo_s = {XLEN{1'b1}};
                res_hi_s = araw_q;
            end else begin
                res_lo_s = neg_if(neg_prod_q, step_acc_s[XLEN-1:0]);
                res_hi_s = neg_if(neg_rem_q, step_acc_s[2*XLEN-1:XLEN]);
            end
        end else begin
            res_lo_s = prod_s[XLEN-1:0];
            res_hi_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Single-cycle ALU result; multicycle and unknown codes give zero.
    always_comb begin
        alu_s = {XLEN{1'b0}};
        case (EXE_alu_ctrl)
            OP_NOP:  alu_s = {XLEN{1'b0}};
            OP_ADD:  alu_s = EXE_a + op_b_s;
            OP_SUB:  alu_s = EXE_a - op_b_s;
            OP_AND:  alu_s = EXE_a & op_b_s;
            OP_OR:   alu_s = EXE_a | op_b_s;
            OP_XOR:  alu_s = EXE_a ^ op_b_s;
            OP_NOR:  alu_s = ~(EXE_a | op_b_s);
            OP_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(EXE_a) < $signed(op_b_s))};
            OP_SLTU: alu_s = {{(XLEN-1){1'b0}}, (EXE_a < op_b_s)};
            OP_SLL:  alu_s = op_b_s << sh_s;
            OP_SRL:  alu_s = op_b_s >> sh_s;
            OP_SRA:  alu_s = $signed(op_b_s) >>> sh_s;
            OP_LUI:  alu_s = {op_b_s[15:0], 16'h0000};
            OP_MFHI: alu_s = hi_q;
            OP_MFLO: alu_s = lo_q;
            OP_MTHI: alu_s = EXE_a;
            OP_MTLO: alu_s = EXE_a;
            OP_LINK: alu_s = EXE_pc + 32'd8;
            default: alu_s = {XLEN{1'b0}};
        endcase
    end

    // Mult/div FSM next state, HI/LO updates and stall request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_d      = acc_q;
        bmag_d     = bmag_q;
        araw_d     = araw_q;
        is_div_d   = is_div_q;
        neg_prod_d = neg_prod_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        stall_s    = 1'b0;
        if (EXE_flush) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_md_s) begin
                        stall_s    = 1'b1;
                        state_d    = ST_BUSY;
                        cnt_d      = {CNT_W{1'b0}};
                        acc_d      = {{XLEN{1'b0}}, a_mag_s};
                        bmag_d     = b_mag_s;
                        araw_d     = EXE_a;
                        is_div_d   = EXE_alu_ctrl[1];
                        neg_prod_d = a_neg_s ^ b_neg_s;
                        neg_rem_d  = a_neg_s;
                        dz_d       = EXE_alu_ctrl[1] & (op_b_s == {XLEN{1'b0}});
                    end else if (EXE_alu_ctrl == OP_MTHI) begin
                        hi_d = EXE_a;
                    end else if (EXE_alu_ctrl == OP_MTLO) begin
                        lo_d = EXE_a;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    stall_s = 1'b1;
                    acc_d   = step_acc_s;
                    if (cnt_q == CNT_LAST) begin
                        hi_d    = res_hi_s;
                        lo_d    = res_lo_s;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                // DONE releases the pipeline once; no restart on the held code.
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counter, HI/LO and latched operand registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            hi_q       <= {XLEN{1'b0}};
            lo_q       <= {XLEN{1'b0}};
            acc_q      <= {(2*XLEN){1'b0}};
            bmag_q     <= {XLEN{1'b0}};
            araw_q     <= {XLEN{1'b0}};
            is_div_q   <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_q      <= acc_d;
            bmag_q     <= bmag_d;
            araw_q     <= araw_d;
            is_div_q   <= is_div_d;
            neg_prod_q <= neg_prod_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
        end
    end

    assign EXE_alu_out = alu_s;
    // The start request is combinational, so it is masked while reset is held.
    assign EXE_stall   = stall_s & reset;
    assign EXE_md_busy = (state_q == ST_BUSY);

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage : self-checking bench for exe_stage. A behavioural model tracks
// HI/LO and the occupancy of the mult/div unit in cycles, computes results
// with native signed/unsigned arithmetic, and is compared every cycle.
// -----------------------------------------------------------------------------
module tb_exe_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        EXE_flush;
    logic [5:0]  EXE_alu_ctrl;
    logic        EXE_s_b;
    logic [31:0] EXE_pc, EXE_a, EXE_b, EXE_ex_imm;
    logic [31:0] EXE_alu_out;
    logic        EXE_stall, EXE_md_busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          occ;          // cycles the current mult/div has spent in EXE (0 = none)
    logic [31:0] last_out;
    logic        last_stall;

    always #5 clock = ~clock;

    exe_stage dut (
        .clock       (clock),
        .reset       (reset),
        .EXE_flush   (EXE_flush),
        .EXE_alu_ctrl(EXE_alu_ctrl),
        .EXE_s_b     (EXE_s_b),
        .EXE_pc      (EXE_pc),
        .EXE_a       (EXE_a),
        .EXE_b       (EXE_b),
        .EXE_ex_imm  (EXE_ex_imm),
        .EXE_alu_out (EXE_alu_out),
        .EXE_stall   (EXE_stall),
        .EXE_md_busy (EXE_md_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc,
                                            input logic [31:0] hi, input logic [31:0] lo);
        int sa, sb;
        sa = a;
        sb = b;
        case (c)
            6'h01: return a + b;
            6'h02: return a - b;
            6'h03: return a & b;
            6'h04: return a | b;
            6'h05: return a ^ b;
            6'h06: return ~(a | b);
            6'h07: return (sa < sb) ? 32'd1 : 32'd0;
            6'h08: return (a < b) ? 32'd1 : 32'd0;
            6'h09: return b << a[4:0];
            6'h0A: return b >> a[4:0];
            6'h0B: return sb >>> a[4:0];
            6'h0C: return b * 32'd65536;
            6'h14: return hi;
            6'h15: return lo;
            6'h16: return a;
            6'h17: return a;
            6'h18: return pc + 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_md(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint      la, lb;
        logic [63:0] p;
        int          sa, sb;
        sa = a;
        sb = b;
        hi = 32'd0;
        lo = 32'd0;
        case (c)
            6'h10: begin la = sa; lb = sb; p = la * lb; hi = p[63:32]; lo = p[31:0]; end
            6'h11: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            6'h12: begin
                if (b == 32'd0) begin lo = 32'hFFFFFFFF; hi = a; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = 32'h80000000; hi = 32'd0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            6'h13: begin
                if (b == 32'd0) begin lo = 32'hFFFFFFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: begin hi = 32'd0; lo = 32'd0; end
        endcase
    endtask

    // Called just after a rising edge; drives one cycle, checks at the falling
    // edge, then advances the model across the next rising edge.
    task automatic do_cycle(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic sb, input logic [31:0] imm, input logic [31:0] pc,
                            input logic fl);
        logic [31:0] opb, e_out;
        logic        e_stall, e_busy, is_md;
        EXE_alu_ctrl = c; EXE_a = a; EXE_b = b; EXE_s_b = sb;
        EXE_ex_imm = imm; EXE_pc = pc; EXE_flush = fl;
        opb   = sb ? imm : b;
        is_md = (c >= 6'h10) && (c <= 6'h13);
        e_out = ref_alu(c, a, opb, pc, m_hi, m_lo);
        if (occ == 0) begin
            e_stall = is_md && !fl; e_busy = 1'b0;
        end else if (occ <= 32) begin
            e_stall = !fl; e_busy = 1'b1;
        end else begin
            e_stall = 1'b0; e_busy = 1'b0;
        end
        @(negedge clock);
        chk("alu_out", EXE_alu_out, e_out);
        chk("stall", {31'd0, EXE_stall}, {31'd0, e_stall});
        chk("md_busy", {31'd0, EXE_md_busy}, {31'd0, e_busy});
        last_out   = EXE_alu_out;
        last_stall = EXE_stall;
        @(posedge clock);
        if (fl) begin
            occ = 0;
        end else if (occ == 0) begin
            if (is_md) begin
                ref_md(c, a, opb, p_hi, p_lo);
                occ = 1;
            end else if (c == 6'h16) begin
                m_hi = a;
            end else if (c == 6'h17) begin
                m_lo = a;
            end
        end else if (occ < 32) begin
            occ++;
        end else if (occ == 32) begin
            m_hi = p_hi; m_lo = p_lo; occ = 33;
        end else begin
            occ = 0;
        end
        #1;
    endtask

    task automatic alu(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        do_cycle(c, a, b, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Hold a mult/div code until the stall drops; returns cycles spent in EXE.
    task automatic run_md(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            alu(c, a, b);
            cycles++;
            if (!last_stall) break;
        end
    endtask

    initial begin
        int n;
        int tot;
        logic [5:0]  rc;
        logic [31:0] ra, rb;

        m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; occ = 0;
        reset = 1'b0; EXE_flush = 1'b0; EXE_alu_ctrl = 6'h10; EXE_s_b = 1'b0;
        EXE_pc = 32'd0; EXE_a = 32'd5; EXE_b = 32'd7; EXE_ex_imm = 32'd0;
        #2;
        chk("rst_stall", {31'd0, EXE_stall}, 32'd0);
        chk("rst_busy", {31'd0, EXE_md_busy}, 32'd0);
        chk("rst_md_out", EXE_alu_out, 32'd0);
        EXE_alu_ctrl = 6'h00;
        #1;
        chk("rst_out", EXE_alu_out, 32'd0);
        #9 reset = 1'b1;                      // released between edges (t=12)
        @(posedge clock); #1;

        alu(6'h14, 32'd0, 32'd0);             chk("rst_hi", last_out, 32'd0);
        alu(6'h15, 32'd0, 32'd0);             chk("rst_lo", last_out, 32'd0);

        // ALU sweep
        alu(6'h01, 32'hF, 32'hFFFFFFF0);      chk("add", last_out, 32'hFFFFFFFF);
        alu(6'h02, 32'hF, 32'hFFFFFFF0);      chk("sub", last_out, 32'h0000001F);
        alu(6'h07, 32'hF, 32'hFFFFFFF0);      chk("slt", last_out, 32'd0);
        alu(6'h08, 32'hF, 32'hFFFFFFF0);      chk("sltu", last_out, 32'd1);
        alu(6'h0B, 32'd4, 32'h80000000);      chk("sra", last_out, 32'hF8000000);
        do_cycle(6'h0C, 32'd0, 32'd0, 1'b1, 32'h00001234, 32'd0, 1'b0);
        chk("lui", last_out, 32'h12340000);
        do_cycle(6'h18, 32'd0, 32'd0, 1'b0, 32'd0, 32'h00400010, 1'b0);
        chk("link", last_out, 32'h00400018);
        alu(6'h1F, 32'h1234, 32'h5678);       chk("illegal", last_out, 32'd0);

        // MULT / MULTU
        run_md(6'h10, 32'hFFFFFFFE, 32'd3, n); chk("mult_cycles", n, 34);
        alu(6'h14, 32'd0, 32'd0);              chk("mult_hi", last_out, 32'hFFFFFFFF);
        alu(6'h15, 32'd0, 32'd0);              chk("mult_lo", last_out, 32'hFFFFFFFA);
        run_md(6'h11, 32'hFFFFFFFE, 32'd3, n); chk("multu_cycles", n, 34);
        alu(6'h14, 32'd0, 32'd0);              chk("multu_hi", last_out, 32'h00000002);
        alu(6'h15, 32'd0, 32'd0);              chk("multu_lo", last_out, 32'hFFFFFFFA);

        // Division
        run_md(6'h12, 32'hFFFFFFF9, 32'd2, n);
        alu(6'h15, 32'd0, 32'd0);              chk("div_lo", last_out, 32'hFFFFFFFD);
        alu(6'h14, 32'd0, 32'd0);              chk("div_hi", last_out, 32'hFFFFFFFF);
        run_md(6'h13, 32'd100, 32'd0, n);
        alu(6'h15, 32'd0, 32'd0);              chk("divz_lo", last_out, 32'hFFFFFFFF);
        alu(6'h14, 32'd0, 32'd0);              chk("divz_hi", last_out, 32'd100);
        run_md(6'h12, 32'h80000000, 32'hFFFFFFFF, n);
        alu(6'h15, 32'd0, 32'd0);              chk("divov_lo", last_out, 32'h80000000);
        alu(6'h14, 32'd0, 32'd0);              chk("divov_hi", last_out, 32'd0);

        // Flush mid-operation
        alu(6'h17, 32'h55, 32'd0);
        alu(6'h13, 32'd10, 32'd3);                         // IDLE start cycle
        for (int i = 0; i < 9; i++) alu(6'h13, 32'd10, 32'd3);
        do_cycle(6'h13, 32'd10, 32'd3, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("flush_stall", {31'd0, last_stall}, 32'd0);
        do_cycle(6'h15, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("flush_lo", last_out, 32'h55);

        // Back-to-back
        run_md(6'h11, 32'd5, 32'd6, n);  tot = n;
        run_md(6'h13, 32'd30, 32'd4, n); tot += n;
        chk("b2b_cycles", tot, 68);
        alu(6'h14, 32'd0, 32'd0);        chk("b2b_hi", last_out, 32'd2);
        alu(6'h15, 32'd0, 32'd0);        chk("b2b_lo", last_out, 32'd7);

        // Async reset mid-BUSY
        for (int i = 0; i < 6; i++) alu(6'h11, 32'hDEAD, 32'hBEEF);
        #2 reset = 1'b0;
        #1;
        chk("arst_stall", {31'd0, EXE_stall}, 32'd0);
        chk("arst_busy", {31'd0, EXE_md_busy}, 32'd0);
        EXE_alu_ctrl = 6'h00;
        m_hi = 32'd0; m_lo = 32'd0; occ = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        alu(6'h14, 32'd0, 32'd0);        chk("arst_hi", last_out, 32'd0);
        alu(6'h15, 32'd0, 32'd0);        chk("arst_lo", last_out, 32'd0);
        run_md(6'h11, 32'd3, 32'd4, n);  chk("fresh_cycles", n, 34);
        alu(6'h15, 32'd0, 32'd0);        chk("fresh_lo", last_out, 32'd12);
        alu(6'h14, 32'd0, 32'd0);        chk("fresh_hi", last_out, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 700; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    rc = 6'h10 + 6'($urandom_range(0, 3));
                2:       rc = ($urandom_range(0, 1) != 0) ? 6'h16 : 6'h17;
                3:       rc = ($urandom_range(0, 1) != 0) ? 6'h14 : 6'h15;
                default: rc = 6'($urandom_range(0, 31));
            endcase
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) ra = 32'h80000000;
            do_cycle(rc, ra, rb, 1'($urandom_range(0, 3) == 0), $urandom, $urandom,
                     1'($urandom_range(0, 39) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
